// File: rtl/vend_sequencer.sv
// Vending sequencer: BCD coin credit, priority item select, refund and a busy hold window.
// Optional AUTO_CHANGE_EN: after a successful vend, leftover credit is refunded on hold exit.
module vend_sequencer #(
    parameter logic [7:0] PRICE_A     = 8'h25,
    parameter logic [7:0] PRICE_B     = 8'h35,
    parameter logic [7:0] PRICE_C     = 8'h50,
    parameter logic [7:0] PRICE_D     = 8'h75,
    parameter int         HOLD_CYCLES = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin5,
    input  logic       coin10,
    input  logic       coin25,
    input  logic       sel_a,
    input  logic       sel_b,
    input  logic       sel_c,
    input  logic       sel_d,
    input  logic       cancel,
    output logic       apple,
    output logic       banana,
    output logic       carrot,
    output logic       date,
    output logic       error,
    output logic [7:0] credit,
    output logic [7:0] change,
    output logic       change_valid,
    output logic       busy,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCUM = 2'd1, S_HOLD = 2'd2, S_REFUND = 2'd3} state_t;

    state_t     state_q, state_d;
    logic [7:0] credit_q, credit_d;
    logic [7:0] change_q, change_d;
    logic       change_valid_q, change_valid_d;
    logic       busy_q, busy_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic       hold_vend_q, hold_vend_d;
    logic [3:0] item_q, item_d;
    logic       error_q, error_d;

    logic [1:0] coin_n;
    logic       coin_any, coin_err, sel_any, vend_ok, idle_accum;
    logic [7:0] coin_val, price, base, applied;
    logic [3:0] sel_hot;
    logic [8:0] sum9;

    // Returns {overflow, bcd_sum}; overflow means the result exceeds 99.
    function automatic logic [8:0] bcd_add(input logic [7:0] a, input logic [7:0] b);
        logic [4:0] lo;
        logic [4:0] hi;
        logic       c;
        lo = {1'b0, a[3:0]} + {1'b0, b[3:0]};
        c  = (lo > 5'd9);
        if (c) lo = lo + 5'd6;
        hi = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0000, c};
        return {(hi > 5'd9), hi[3:0], lo[3:0]};
    endfunction

    // Caller guarantees a >= b, so the result is always a valid BCD value.
    function automatic logic [7:0] bcd_sub(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] lo;
        logic [3:0] hi;
        logic       br;
        br = (a[3:0] < b[3:0]);
        lo = br ? (a[3:0] + 4'd10 - b[3:0]) : (a[3:0] - b[3:0]);
        hi = a[7:4] - b[7:4] - {3'b000, br};
        return {hi, lo};
    endfunction

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        change_d       = change_q;
        change_valid_d = 1'b0;
        hold_cnt_d     = hold_cnt_q;
        hold_vend_d    = hold_vend_q;
        item_d         = 4'b0000;
        error_d        = 1'b0;

        coin_n   = {1'b0, coin5} + {1'b0, coin10} + {1'b0, coin25};
        coin_any = (coin_n != 2'd0);
        coin_val = coin25 ? 8'h25 : (coin10 ? 8'h10 : (coin5 ? 8'h05 : 8'h00));

        sel_any = sel_a | sel_b | sel_c | sel_d;
        if (sel_a) begin
            price = PRICE_A; sel_hot = 4'b0001;
        end else if (sel_b) begin
            price = PRICE_B; sel_hot = 4'b0010;
        end else if (sel_c) begin
            price = PRICE_C; sel_hot = 4'b0100;
        end else begin
            price = PRICE_D; sel_hot = 4'b1000;
        end

        // The vend (if any) is applied first, then the coin on top of what is left.
        idle_accum = (state_q == S_IDLE) || (state_q == S_ACCUM);
        vend_ok    = idle_accum && sel_any && (credit_q >= price);
        base       = vend_ok ? bcd_sub(credit_q, price) : credit_q;
        sum9       = bcd_add(base, coin_val);
        coin_err   = coin_any && ((coin_n > 2'd1) || sum9[8]);
        applied    = (coin_any && !coin_err) ? sum9[7:0] : base;

        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (sel_any) begin
                    state_d     = S_HOLD;
                    hold_cnt_d  = 4'(HOLD_CYCLES - 1);
                    hold_vend_d = vend_ok;
                    credit_d    = applied;
                    if (vend_ok) item_d  = sel_hot;
                    else         error_d = 1'b1;
                end else if (cancel && (state_q == S_ACCUM)) begin
                    state_d        = S_REFUND;
                    change_d       = applied;
                    change_valid_d = 1'b1;
                    credit_d       = 8'h00;
                    error_d        = coin_err;
                end else begin
                    credit_d = applied;
                    error_d  = coin_err;
                    state_d  = (applied == 8'h00) ? S_IDLE : S_ACCUM;
                end
            end
            S_HOLD: begin
                // Coin errors are silent here so the held message is not overwritten.
                credit_d = applied;
                if (hold_cnt_q == 4'd0) begin
`ifdef AUTO_CHANGE_EN
                    if (hold_vend_q && (applied != 8'h00)) begin
                        state_d        = S_REFUND;
                        change_d       = applied;
                        change_valid_d = 1'b1;
                        credit_d       = 8'h00;
                    end else begin
                        state_d = (applied == 8'h00) ? S_IDLE : S_ACCUM;
                    end
`else
                    state_d = (applied == 8'h00) ? S_IDLE : S_ACCUM;
`endif
                end else begin
                    hold_cnt_d = hold_cnt_q - 4'd1;
                end
            end
            default: begin
                credit_d = applied;
                error_d  = coin_err;
                state_d  = (applied == 8'h00) ? S_IDLE : S_ACCUM;
            end
        endcase

        busy_d = (state_d == S_HOLD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            credit_q       <= 8'h00;
            change_q       <= 8'h00;
            change_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            hold_cnt_q     <= 4'd0;
            hold_vend_q    <= 1'b0;
            item_q         <= 4'b0000;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            change_q       <= change_d;
            change_valid_q <= change_valid_d;
            busy_q         <= busy_d;
            hold_cnt_q     <= hold_cnt_d;
            hold_vend_q    <= hold_vend_d;
            item_q         <= item_d;
            error_q        <= error_d;
        end
    end

    assign apple        = item_q[0];
    assign banana       = item_q[1];
    assign carrot       = item_q[2];
    assign date         = item_q[3];
    assign error        = error_q;
    assign credit       = credit_q;
    assign change       = change_q;
    assign change_valid = change_valid_q;
    assign busy         = busy_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed self-checking bench for vend_sequencer; honours AUTO_CHANGE_EN like the design.
module tb_vend_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic coin5, coin10, coin25, sel_a, sel_b, sel_c, sel_d, cancel;
    logic apple, banana, carrot, date, error, change_valid, busy;
    logic [7:0] credit, change;
    logic [1:0] state_dbg;

    int tests_run = 0;
    int tests_failed = 0;

    // Stimulus word: {cancel, sel_d, sel_c, sel_b, sel_a, coin25, coin10, coin5}
    localparam logic [7:0] C5 = 8'h01, C10 = 8'h02, C25 = 8'h04;
    localparam logic [7:0] SA = 8'h08, SB = 8'h10, SC = 8'h20, CAN = 8'h80;

    vend_sequencer dut (
        .clk(clk), .reset(rst_n),
        .coin5(coin5), .coin10(coin10), .coin25(coin25),
        .sel_a(sel_a), .sel_b(sel_b), .sel_c(sel_c), .sel_d(sel_d), .cancel(cancel),
        .apple(apple), .banana(banana), .carrot(carrot), .date(date), .error(error),
        .credit(credit), .change(change), .change_valid(change_valid),
        .busy(busy), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic set_in(input logic [7:0] v);
        {cancel, sel_d, sel_c, sel_b, sel_a, coin25, coin10, coin5} = v;
    endtask

    // Apply v for one rising edge, then sample 1 time unit after that edge.
    task automatic drive(input logic [7:0] v);
        set_in(v);
        @(posedge clk);
        #1;
        set_in(8'h00);
    endtask

    task automatic do_reset();
        set_in(8'h00);
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Counts busy samples (including the current one) and ORs any event pulse after the first.
    task automatic wait_hold(input logic [7:0] first_in, output int n, output logic ev_seen);
        n = 0;
        ev_seen = 1'b0;
        if (busy) n = 1;
        drive(first_in);
        ev_seen = apple | banana | carrot | date | error;
        while (busy && n < 20) begin
            n++;
            drive(8'h00);
            ev_seen = ev_seen | apple | banana | carrot | date | error;
        end
    endtask

    task automatic test_reset();
        set_in(8'h00);
        rst_n = 1'b0;
        #2;
        tests_run++;
        if ({credit, change} !== 16'h0000) begin
            tests_failed++; $display("FAIL reset_regs credit=%h change=%h want 00/00", credit, change);
        end
        tests_run++;
        if ({apple, banana, carrot, date, error, change_valid, busy, state_dbg} !== 9'b0) begin
            tests_failed++;
            $display("FAIL reset_flags got %b want 0", {apple, banana, carrot, date, error, change_valid, busy, state_dbg});
        end
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_vend_hold();
        int n;
        logic ev;
        do_reset();
        drive(C25);
        tests_run++;
        if (credit !== 8'h25) begin tests_failed++; $display("FAIL coin25 credit=%h want 25", credit); end
        drive(C10);
        tests_run++;
        if (credit !== 8'h35) begin tests_failed++; $display("FAIL coin10 credit=%h want 35", credit); end
        drive(SA);
        tests_run++;
        if ({apple, busy, credit} !== {2'b11, 8'h10}) begin
            tests_failed++; $display("FAIL vend_a apple=%b busy=%b credit=%h want 1/1/10", apple, busy, credit);
        end
        wait_hold(SA, n, ev);
        tests_run++;
        if (n !== 6) begin tests_failed++; $display("FAIL hold_len busy_cycles=%0d want 6", n); end
        tests_run++;
        if (ev !== 1'b0) begin tests_failed++; $display("FAIL hold_sel_ignored event seen=%b want 0", ev); end
        tests_run++;
        if ({credit, state_dbg} !== {8'h10, 2'd1}) begin
            tests_failed++; $display("FAIL hold_exit credit=%h state=%0d want 10/1", credit, state_dbg);
        end
    endtask

    task automatic test_price_error();
        int n;
        logic ev;
        do_reset();
        drive(C10);
        drive(C10);
        drive(SC);
        tests_run++;
        if ({error, carrot, busy, credit} !== {3'b101, 8'h20}) begin
            tests_failed++;
            $display("FAIL price_err error=%b carrot=%b busy=%b credit=%h want 1/0/1/20", error, carrot, busy, credit);
        end
        wait_hold(8'h00, n, ev);
        tests_run++;
        if (n !== 6 || credit !== 8'h20) begin
            tests_failed++; $display("FAIL price_err_hold cycles=%0d credit=%h want 6/20", n, credit);
        end
    endtask

    task automatic test_overflow_multi();
        do_reset();
        drive(C5 | C25);
        tests_run++;
        if ({error, credit} !== {1'b1, 8'h00}) begin
            tests_failed++; $display("FAIL multi_coin_zero error=%b credit=%h want 1/00", error, credit);
        end
        drive(C25); drive(C25); drive(C25); drive(C10); drive(C10);
        tests_run++;
        if (credit !== 8'h95) begin tests_failed++; $display("FAIL build_95 credit=%h want 95", credit); end
        drive(C10);
        tests_run++;
        if ({error, credit} !== {1'b1, 8'h95}) begin
            tests_failed++; $display("FAIL overflow error=%b credit=%h want 1/95", error, credit);
        end
        drive(8'h00);
        tests_run++;
        if (error !== 1'b0) begin tests_failed++; $display("FAIL error_one_cycle error=%b want 0", error); end
        drive(C5 | C10);
        tests_run++;
        if ({error, credit} !== {1'b1, 8'h95}) begin
            tests_failed++; $display("FAIL multi_coin error=%b credit=%h want 1/95", error, credit);
        end
    endtask

    task automatic test_cancel_coin();
        do_reset();
        drive(CAN);
        tests_run++;
        if ({change_valid, credit} !== {1'b0, 8'h00}) begin
            tests_failed++; $display("FAIL cancel_idle change_valid=%b credit=%h want 0/00", change_valid, credit);
        end
        drive(C25); drive(C10); drive(C10);
        drive(CAN | C5);
        tests_run++;
        if ({change_valid, change, credit, error} !== {1'b1, 8'h50, 8'h00, 1'b0}) begin
            tests_failed++;
            $display("FAIL cancel_coin cv=%b change=%h credit=%h error=%b want 1/50/00/0", change_valid, change, credit, error);
        end
        drive(8'h00);
        tests_run++;
        if ({change_valid, state_dbg} !== {1'b0, 2'd0}) begin
            tests_failed++; $display("FAIL refund_end cv=%b state=%0d want 0/0", change_valid, state_dbg);
        end
    endtask

    task automatic test_coin_with_vend();
        int n;
        logic ev;
        do_reset();
        drive(C25); drive(C25);
        tests_run++;
        if (credit !== 8'h50) begin tests_failed++; $display("FAIL bcd_carry credit=%h want 50", credit); end
        drive(SB | C10);
        tests_run++;
        if ({banana, apple, error, credit} !== {3'b100, 8'h25}) begin
            tests_failed++;
            $display("FAIL vend_b_coin banana=%b apple=%b error=%b credit=%h want 1/0/0/25", banana, apple, error, credit);
        end
        wait_hold(C5 | C10, n, ev);
        tests_run++;
        if ({ev, credit} !== {1'b0, 8'h25} || n !== 6) begin
            tests_failed++; $display("FAIL hold_coin_err ev=%b credit=%h cycles=%0d want 0/25/6", ev, credit, n);
        end
    endtask

    task automatic test_auto_change();
        int n;
        logic ev;
        do_reset();
        drive(C25); drive(C25);
        drive(SA | SB);
        tests_run++;
        if ({apple, banana, credit} !== {2'b10, 8'h25}) begin
            tests_failed++; $display("FAIL priority apple=%b banana=%b credit=%h want 1/0/25", apple, banana, credit);
        end
        wait_hold(8'h00, n, ev);
`ifdef AUTO_CHANGE_EN
        tests_run++;
        if ({change_valid, change, credit} !== {1'b1, 8'h25, 8'h00} || n !== 6) begin
            tests_failed++;
            $display("FAIL auto_change cv=%b change=%h credit=%h cycles=%0d want 1/25/00/6", change_valid, change, credit, n);
        end
`else
        tests_run++;
        if ({change_valid, credit, state_dbg} !== {1'b0, 8'h25, 2'd1} || n !== 6) begin
            tests_failed++;
            $display("FAIL keep_credit cv=%b credit=%h state=%0d cycles=%0d want 0/25/1/6", change_valid, credit, state_dbg, n);
        end
`endif
    endtask

    task automatic test_async_reset();
        int n;
        logic ev;
        do_reset();
        drive(C25); drive(C10); drive(C5);
        tests_run++;
        if (credit !== 8'h40) begin tests_failed++; $display("FAIL build_40 credit=%h want 40", credit); end
        drive(8'h00);
        drive(SA);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({credit, apple, error, busy, change_valid, state_dbg} !== 14'b0) begin
            tests_failed++;
            $display("FAIL async_reset credit=%h apple=%b busy=%b state=%0d want all 0", credit, apple, busy, state_dbg);
        end
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        wait_hold(8'h00, n, ev);
        tests_run++;
        if (n !== 0 || credit !== 8'h00) begin
            tests_failed++; $display("FAIL post_reset busy_cycles=%0d credit=%h want 0/00", n, credit);
        end
    endtask

    initial begin
        set_in(8'h00);
        rst_n = 1'b0;
        test_reset();
        test_vend_hold();
        test_price_error();
        test_overflow_multi();
        test_cancel_coin();
        test_coin_with_vend();
        test_auto_change();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
